// File: rtl/nat_lookup_arbiter_if.sv
// Handshake bundle between the tx/rx tuple streams, the arbiter
// and the NAT connection hash engine.
interface nat_lookup_arbiter_if #(
  parameter int TUPLE_W  = 128,
  parameter int RESULT_W = 16
);
  logic [TUPLE_W-1:0]  tx_req_data;
  logic                tx_req_valid;
  logic                tx_req_ready;
  logic [RESULT_W-1:0] tx_rsp_data;
  logic                tx_rsp_valid;
  logic                tx_rsp_miss;
  logic [TUPLE_W-1:0]  rx_req_data;
  logic                rx_req_valid;
  logic                rx_req_ready;
  logic [RESULT_W-1:0] rx_rsp_data;
  logic                rx_rsp_valid;
  logic                rx_rsp_miss;
  logic [TUPLE_W-1:0]  eng_tuple_data_0;
  logic [TUPLE_W-1:0]  eng_tuple_data_1;
  logic                eng_tuple_valid_0;
  logic                eng_tuple_valid_1;
  logic [RESULT_W-1:0] eng_conn_data_0;
  logic [RESULT_W-1:0] eng_conn_data_1;
  logic                eng_conn_valid_0;
  logic                eng_conn_valid_1;
  logic                eng_reset;

  modport slave (
    input  tx_req_data, tx_req_valid,
    input  rx_req_data, rx_req_valid,
    input  eng_conn_data_0, eng_conn_data_1,
    input  eng_conn_valid_0, eng_conn_valid_1,
    output tx_req_ready, tx_rsp_data,
    output tx_rsp_valid, tx_rsp_miss,
    output rx_req_ready, rx_rsp_data,
    output rx_rsp_valid, rx_rsp_miss,
    output eng_tuple_data_0, eng_tuple_data_1,
    output eng_tuple_valid_0, eng_tuple_valid_1,
    output eng_reset
  );

  modport master (
    output tx_req_data, tx_req_valid,
    output rx_req_data, rx_req_valid,
    output eng_conn_data_0, eng_conn_data_1,
    output eng_conn_valid_0, eng_conn_valid_1,
    input  tx_req_ready, tx_rsp_data,
    input  tx_rsp_valid, tx_rsp_miss,
    input  rx_req_ready, rx_rsp_data,
    input  rx_rsp_valid, rx_rsp_miss,
    input  eng_tuple_data_0, eng_tuple_data_1,
    input  eng_tuple_valid_0, eng_tuple_valid_1,
    input  eng_reset
  );
endinterface

// File: rtl/nat_lookup_arbiter.sv
// Round-robin tx/rx sharing of the NAT hash engine, one lookup in flight,
// timeout recovery via eng_reset pulse. NAT_ARB_STATS_EN adds counters.
module nat_lookup_arbiter #(
  parameter int TUPLE_W   = 128,
  parameter int RESULT_W  = 16,
  parameter int TIMEOUT   = 1024,
  parameter int TMO_W     = 11,
  parameter int FLUSH_LEN = 4
) (
  input logic clk,
  input logic reset,
  nat_lookup_arbiter_if.slave bus
`ifdef NAT_ARB_STATS_EN
  ,
  output logic [31:0] stat_tx_grants,
  output logic [31:0] stat_rx_grants,
  output logic [15:0] stat_timeouts
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } state_e;

  localparam int FL_W = $clog2(FLUSH_LEN + 1);

  state_e              state_q, state_d;
  logic [1:0]          held_q, held_d;
  logic [1:0]          vreg_q, vreg_d;
  logic [1:0]          rv_q, rv_d;
  logic [1:0]          miss_q, miss_d;
  logic [1:0]          clr;
  logic [1:0]          grant;
  logic                gnt_q, gnt_d;
  logic                rr_q, rr_d;
  logic [TMO_W-1:0]    tmr_q, tmr_d;
  logic [FL_W-1:0]     fl_q, fl_d;
  logic [RESULT_W-1:0] rd_q, rd_d;
  logic [TUPLE_W-1:0]  tx_slot_q;
  logic [TUPLE_W-1:0]  rx_slot_q;
  logic                cv;
  logic [RESULT_W-1:0] cd;
  logic                tmo;

  assign cv  = gnt_q ? bus.eng_conn_valid_1 : bus.eng_conn_valid_0;
  assign cd  = gnt_q ? bus.eng_conn_data_1 : bus.eng_conn_data_0;
  assign tmo = (tmr_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    vreg_d  = vreg_q;
    tmr_d   = tmr_q;
    fl_d    = fl_q;
    rv_d    = '0;
    miss_d  = '0;
    rd_d    = '0;
    clr     = '0;
    grant   = '0;
    unique case (state_q)
      IDLE: begin
        if (|held_q) begin
          gnt_d   = (&held_q) ? ~rr_q : held_q[1];
          vreg_d  = gnt_d ? 2'b10 : 2'b01;
          grant   = vreg_d;
          tmr_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // a response beats a coincident timeout
        if (cv) begin
          rv_d    = gnt_q ? 2'b10 : 2'b01;
          rd_d    = cd;
          clr     = rv_d;
          vreg_d  = '0;
          rr_d    = gnt_q;
          state_d = IDLE;
        end else if (tmo) begin
          rv_d    = gnt_q ? 2'b10 : 2'b01;
          miss_d  = rv_d;
          clr     = rv_d;
          vreg_d  = '0;
          rr_d    = gnt_q;
          fl_d    = '0;
          state_d = FLUSH;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      FLUSH: begin
        if (fl_q == FL_W'(FLUSH_LEN - 1)) begin
          state_d = IDLE;
        end else begin
          fl_d = fl_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign held_d = (held_q & ~clr)
                | ({bus.rx_req_valid, bus.tx_req_valid} & ~held_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= '0;
      vreg_q  <= '0;
      rv_q    <= '0;
      miss_q  <= '0;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b1;
      tmr_q   <= '0;
      fl_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      vreg_q  <= vreg_d;
      rv_q    <= rv_d;
      miss_q  <= miss_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      tmr_q   <= tmr_d;
      fl_q    <= fl_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.tx_req_valid && !held_q[0]) tx_slot_q <= bus.tx_req_data;
    if (bus.rx_req_valid && !held_q[1]) rx_slot_q <= bus.rx_req_data;
  end

  // slot data is stable while held, so it feeds the engine directly
  assign bus.eng_tuple_data_0  = tx_slot_q;
  assign bus.eng_tuple_data_1  = rx_slot_q;
  assign bus.eng_tuple_valid_0 = vreg_q[0] & ~bus.eng_conn_valid_0;
  assign bus.eng_tuple_valid_1 = vreg_q[1] & ~bus.eng_conn_valid_1;
  assign bus.eng_reset         = (state_q != FLUSH);
  assign bus.tx_req_ready      = ~held_q[0];
  assign bus.rx_req_ready      = ~held_q[1];
  assign bus.tx_rsp_valid      = rv_q[0];
  assign bus.rx_rsp_valid      = rv_q[1];
  assign bus.tx_rsp_miss       = miss_q[0];
  assign bus.rx_rsp_miss       = miss_q[1];
  assign bus.tx_rsp_data       = rd_q & {RESULT_W{rv_q[0]}};
  assign bus.rx_rsp_data       = rd_q & {RESULT_W{rv_q[1]}};

`ifdef NAT_ARB_STATS_EN
  logic [31:0] stx_q, srx_q;
  logic [15:0] stm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stx_q <= '0;
      srx_q <= '0;
      stm_q <= '0;
    end else begin
      if (grant[0] && !(&stx_q)) stx_q <= stx_q + 1'b1;
      if (grant[1] && !(&srx_q)) srx_q <= srx_q + 1'b1;
      if ((|miss_d) && !(&stm_q)) stm_q <= stm_q + 1'b1;
    end
  end

  assign stat_tx_grants = stx_q;
  assign stat_rx_grants = srx_q;
  assign stat_timeouts  = stm_q;
`endif

endmodule

// File: tb/tb_nat_lookup_arbiter.sv
// Directed/randomized bench for nat_lookup_arbiter with an engine model
// that answers tuple[15:0] after a random latency.
module tb_nat_lookup_arbiter;
  localparam int TW  = 128;
  localparam int RW  = 16;
  localparam int TMO = 1024;
  localparam int FL  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nat_lookup_arbiter_if #(.TUPLE_W(TW), .RESULT_W(RW)) bus ();

`ifdef NAT_ARB_STATS_EN
  logic [31:0] stx, srx;
  logic [15:0] stm;
`endif

  nat_lookup_arbiter #(
    .TUPLE_W(TW), .RESULT_W(RW), .TIMEOUT(TMO),
    .TMO_W(11), .FLUSH_LEN(FL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef NAT_ARB_STATS_EN
    ,
    .stat_tx_grants(stx),
    .stat_rx_grants(srx),
    .stat_timeouts(stm)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  int fixed_lat = 0;
  bit mute1 = 0;
  bit spur1 = 0;
  int acc[2];
  bit pend[2];
  int cnt[2];
  logic [15:0] res[2];
  int mask_bad = 0;
  int flush_bad = 0;
  int cyc = 0;
  logic [16:0] txq[$];
  logic [16:0] rxq[$];
  int rxc[$];
  int gq[$];
  int gcyc[$];
  int flens[$];
  int flen = 0;
  bit pv0 = 0, pv1 = 0;
  logic [15:0] exp_tx[$];
  logic [15:0] exp_rx[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rand_tuple();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  // engine model and monitor
  initial begin
    int lat;
    acc = '{0, 0};
    pend = '{0, 0};
    cnt = '{0, 0};
    res = '{16'h0, 16'h0};
    bus.eng_conn_valid_0 = 0;
    bus.eng_conn_valid_1 = 0;
    bus.eng_conn_data_0 = '0;
    bus.eng_conn_data_1 = '0;
    forever begin
      @(negedge clk);
      bus.eng_conn_valid_0 = 0;
      bus.eng_conn_valid_1 = 0;
      #1;
      cyc++;
      if (bus.tx_rsp_valid)
        txq.push_back({bus.tx_rsp_miss, bus.tx_rsp_data});
      if (bus.rx_rsp_valid) begin
        rxq.push_back({bus.rx_rsp_miss, bus.rx_rsp_data});
        rxc.push_back(cyc);
      end
      if (bus.eng_tuple_valid_0 && !pv0) begin
        gq.push_back(0);
        gcyc.push_back(cyc);
      end
      if (bus.eng_tuple_valid_1 && !pv1) begin
        gq.push_back(1);
        gcyc.push_back(cyc);
      end
      pv0 = bus.eng_tuple_valid_0;
      pv1 = bus.eng_tuple_valid_1;
      if (!bus.eng_reset) begin
        flen++;
        if (bus.eng_tuple_valid_0 || bus.eng_tuple_valid_1) flush_bad++;
      end else if (flen != 0) begin
        flens.push_back(flen);
        flen = 0;
      end
      if (reset || !bus.eng_reset) begin
        pend = '{0, 0};
      end else begin
        if (pend[0]) begin
          if (cnt[0] == 0) begin
            bus.eng_conn_data_0 = res[0];
            bus.eng_conn_valid_0 = 1;
            pend[0] = 0;
          end else cnt[0]--;
        end else if (bus.eng_tuple_valid_0) begin
          acc[0]++;
          res[0] = bus.eng_tuple_data_0[15:0];
          lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
          cnt[0] = lat - 1;
          pend[0] = 1;
        end
        if (pend[1]) begin
          if (cnt[1] == 0 && !mute1) begin
            bus.eng_conn_data_1 = res[1];
            bus.eng_conn_valid_1 = 1;
            pend[1] = 0;
          end else if (cnt[1] != 0) cnt[1]--;
        end else if (bus.eng_tuple_valid_1) begin
          acc[1]++;
          res[1] = bus.eng_tuple_data_1[15:0];
          lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
          cnt[1] = lat - 1;
          pend[1] = 1;
        end else if (spur1) begin
          bus.eng_conn_data_1 = 16'hdead;
          bus.eng_conn_valid_1 = 1;
          spur1 = 0;
        end
      end
      #1;
      if (bus.eng_conn_valid_0 && bus.eng_tuple_valid_0 !== 1'b0) mask_bad++;
      if (bus.eng_conn_valid_1 && bus.eng_tuple_valid_1 !== 1'b0) mask_bad++;
    end
  end

  task automatic send(input bit side, input logic [127:0] t);
    bit r;
    if (!side) begin
      bus.tx_req_data = t;
      bus.tx_req_valid = 1;
      r = bus.tx_req_ready;
    end else begin
      bus.rx_req_data = t;
      bus.rx_req_valid = 1;
      r = bus.rx_req_ready;
    end
    for (int c = 0; c < 3000 && !r; c++) begin
      step();
      r = side ? bus.rx_req_ready : bus.tx_req_ready;
    end
    if (!r) chk("send accept", 0, 1);
    step();
    bus.tx_req_valid = 0;
    bus.rx_req_valid = 0;
  endtask

  task automatic feed(input int ntx, input int nrx);
    int stx, srx;
    bit rtx, rrx;
    stx = 0; srx = 0; rtx = 0; rrx = 0;
    for (int c = 0; c < 2000 && (stx < ntx || srx < nrx ||
         bus.tx_req_valid || bus.rx_req_valid); c++) begin
      step();
      if (bus.tx_req_valid && rtx) begin
        exp_tx.push_back(bus.tx_req_data[15:0]);
        stx++;
        bus.tx_req_valid = 0;
      end
      if (!bus.tx_req_valid && stx < ntx) begin
        bus.tx_req_data = rand_tuple();
        bus.tx_req_valid = 1;
      end
      rtx = bus.tx_req_ready;
      if (bus.rx_req_valid && rrx) begin
        exp_rx.push_back(bus.rx_req_data[15:0]);
        srx++;
        bus.rx_req_valid = 0;
      end
      if (!bus.rx_req_valid && srx < nrx) begin
        bus.rx_req_data = rand_tuple();
        bus.rx_req_valid = 1;
      end
      rrx = bus.rx_req_ready;
    end
    chk("feed tx sent", stx, ntx);
    chk("feed rx sent", srx, nrx);
  endtask

  task automatic wait_q(input int nt, input int nr, input string tag);
    for (int c = 0; c < 3000 && (txq.size() < nt || rxq.size() < nr); c++)
      step();
    repeat (3) step();
    chk({tag, " tx rsp count"}, txq.size(), nt);
    chk({tag, " rx rsp count"}, rxq.size(), nr);
  endtask

  initial begin
    int a0, a1, same, g0;
    logic [127:0] t;
    bus.tx_req_valid = 0;
    bus.rx_req_valid = 0;
    bus.tx_req_data = '0;
    bus.rx_req_data = '0;
    repeat (3) step();
    chk("rst tx_req_ready", bus.tx_req_ready, 1);
    chk("rst rx_req_ready", bus.rx_req_ready, 1);
    chk("rst tx_rsp_valid", bus.tx_rsp_valid, 0);
    chk("rst rx_rsp_valid", bus.rx_rsp_valid, 0);
    chk("rst tx_rsp_data", bus.tx_rsp_data, 0);
    chk("rst eng_valid_0", bus.eng_tuple_valid_0, 0);
    chk("rst eng_valid_1", bus.eng_tuple_valid_1, 0);
    chk("rst eng_reset", bus.eng_reset, 1);
    reset = 0;
    step();

    // backlog on both sides: grants must alternate, tx first
    gq.delete();
    a0 = acc[0]; a1 = acc[1];
    feed(6, 6);
    wait_q(6, 6, "T2");
    chk("T2 first grant tx", gq.size() > 0 ? gq[0] : -1, 0);
    chk("T2 grant count", gq.size(), 12);
    same = 0;
    for (int i = 1; i < gq.size(); i++) if (gq[i] == gq[i-1]) same++;
    chk("T2 repeated grants", same, 0);
    chk("T2 tx acceptances", acc[0] - a0, 6);
    chk("T2 rx acceptances", acc[1] - a1, 6);
    while (txq.size() > 0 && exp_tx.size() > 0)
      chk("T2 tx result", txq.pop_front(), {1'b0, exp_tx.pop_front()});
    while (rxq.size() > 0 && exp_rx.size() > 0)
      chk("T2 rx result", rxq.pop_front(), {1'b0, exp_rx.pop_front()});
    txq.delete(); rxq.delete();

    // single tx lookup, engine latency 5
    fixed_lat = 5;
    a0 = acc[0];
    t = rand_tuple();
    t[15:0] = 16'h0300;
    send(0, t);
    wait_q(1, 0, "T1");
    if (txq.size() > 0) chk("T1 tx result", txq.pop_front(), 17'h00300);
    chk("T1 tx_req_ready", bus.tx_req_ready, 1);
    chk("T1 acceptances", acc[0] - a0, 1);
    chk("T4 mask violations", mask_bad, 0);

    // spurious rx engine result during a tx lookup
    fixed_lat = 8;
    t = rand_tuple();
    send(0, t);
    repeat (2) step();
    spur1 = 1;
    wait_q(1, 0, "T5");
    if (txq.size() > 0) chk("T5 tx result", txq.pop_front(), {1'b0, t[15:0]});
    chk("T5 no rx rsp", rxq.size(), 0);
    txq.delete(); rxq.delete();

    // rx lookup never answered: timeout, miss, flush
    fixed_lat = 0;
    mute1 = 1;
    gq.delete(); gcyc.delete(); rxc.delete(); flens.delete();
    send(1, rand_tuple());
    wait_q(0, 1, "T3");
    mute1 = 0;
    if (rxq.size() > 0) chk("T3 rx miss rsp", rxq.pop_front(), 17'h10000);
    g0 = (gcyc.size() > 0 && rxc.size() > 0) ? rxc[0] - gcyc[0] : -1;
    chk("T3 grant to miss", g0, TMO);
    repeat (8) step();
    chk("T3 flush length", flens.size() > 0 ? flens[0] : -1, FL);
    chk("T3 flush pulses", flens.size(), 1);
    chk("T3 flush valids", flush_bad, 0);
    chk("T3 rx_req_ready", bus.rx_req_ready, 1);
    t = rand_tuple();
    send(0, t);
    wait_q(1, 0, "T3 after");
    if (txq.size() > 0) chk("T3 tx after", txq.pop_front(), {1'b0, t[15:0]});
    txq.delete(); rxq.delete();

    // reset during WAIT
    fixed_lat = 20;
    send(0, rand_tuple());
    repeat (4) step();
    chk("T6 in wait", bus.eng_tuple_valid_0, 1);
    reset = 1;
    #1;
    chk("T6 rst eng_valid_0", bus.eng_tuple_valid_0, 0);
    chk("T6 rst tx_req_ready", bus.tx_req_ready, 1);
    chk("T6 rst eng_reset", bus.eng_reset, 1);
    chk("T6 rst tx_rsp_valid", bus.tx_rsp_valid, 0);
    repeat (2) step();
`ifdef NAT_ARB_STATS_EN
    chk("T6 stat tx reset", stx, 0);
    chk("T6 stat to reset", stm, 0);
`endif
    reset = 0;
    fixed_lat = 0;
    step();
    txq.delete(); rxq.delete();
    t = rand_tuple();
    send(0, t);
    wait_q(1, 0, "T6");
    if (txq.size() > 0) chk("T6 tx result", txq.pop_front(), {1'b0, t[15:0]});
`ifdef NAT_ARB_STATS_EN
    chk("T6 stat tx one", stx, 1);
    chk("T6 stat rx zero", srx, 0);
`endif
    chk("final mask violations", mask_bad, 0);
    chk("final flush valids", flush_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
